// File: rtl/vga_display_ctrl_if.sv
// Timer / frame-buffer side of the VGA display controller.
// pixel_pulse qualifies col/row/pixel_data/addr_last for one clk; addr_enable is the same-clk acknowledge.
interface vga_display_ctrl_if;
    logic       pixel_pulse;
    logic [9:0] col;
    logic [9:0] row;
    logic [7:0] pixel_data;
    logic       addr_last;
    logic       addr_enable;

    modport master (
        output pixel_pulse, col, row, pixel_data, addr_last,
        input  addr_enable
    );
    modport slave (
        input  pixel_pulse, col, row, pixel_data, addr_last,
        output addr_enable
    );
endinterface

// File: rtl/vga_display_ctrl.sv
// VGA display controller: frame-buffer address strobes, syncs and RGB through a 2-strobe pipeline.
// Optional colour-bar generator enabled by macro VGA_TEST_PATTERN_EN (adds pattern_sel).
module vga_display_ctrl #(
    parameter logic [9:0] H_ACTIVE     = 10'd640,
    parameter logic [9:0] H_SYNC_START = 10'd656,
    parameter logic [9:0] H_SYNC_END   = 10'd752,
    parameter logic [9:0] V_ACTIVE     = 10'd480,
    parameter logic [9:0] V_SYNC_START = 10'd490,
    parameter logic [9:0] V_SYNC_END   = 10'd492
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
`ifdef VGA_TEST_PATTERN_EN
    input  logic              pattern_sel,
`endif
    vga_display_ctrl_if.slave bus,
    output logic              hsync,
    output logic              vsync,
    output logic              blank_n,
    output logic [2:0]        red,
    output logic [2:0]        green,
    output logic [1:0]        blue,
    output logic              sync_err,
    output logic              dbg_state
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e     state_q, state_d;
    logic       act_a_q, act_a_d, hs_a_q, hs_a_d, vs_a_q, vs_a_d;
    logic       blank_n_q, blank_n_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic [7:0] rgb_q, rgb_d;
    logic       sync_err_q, sync_err_d;
    logic       active, hs, vs, start, running, advance, at_last;
    logic [7:0] pix_rgb;
`ifdef VGA_TEST_PATTERN_EN
    logic [9:0] col_a_q, col_a_d, bar_idx;
`endif

    always_comb begin
        active  = (bus.col < H_ACTIVE) && (bus.row < V_ACTIVE);
        hs      = (bus.col >= H_SYNC_START) && (bus.col < H_SYNC_END);
        vs      = (bus.row >= V_SYNC_START) && (bus.row < V_SYNC_END);
        // The strobe that finds the origin is already the first RUN pixel.
        start   = (state_q == IDLE) && enable && bus.pixel_pulse &&
                  (bus.col == 10'd0) && (bus.row == 10'd0);
        running = (state_q == RUN) || start;
        advance = bus.pixel_pulse && running && active;
        at_last = (bus.col == H_ACTIVE - 10'd1) && (bus.row == V_ACTIVE - 10'd1);

        pix_rgb = bus.pixel_data;
`ifdef VGA_TEST_PATTERN_EN
        bar_idx = col_a_q / (H_ACTIVE >> 3);
        if (pattern_sel) begin
            pix_rgb = (bar_idx >= 10'd7) ? 8'hFF : ({5'd0, bar_idx[2:0]} * 8'h24);
        end
        col_a_d = col_a_q;
`endif

        state_d    = state_q;
        act_a_d    = act_a_q;
        hs_a_d     = hs_a_q;
        vs_a_d     = vs_a_q;
        blank_n_d  = blank_n_q;
        hsync_d    = hsync_q;
        vsync_d    = vsync_q;
        rgb_d      = rgb_q;
        sync_err_d = sync_err_q | (advance & (at_last ^ bus.addr_last));

        if ((state_q == RUN) && !enable) begin
            state_d   = IDLE;
            act_a_d   = 1'b0;
            hs_a_d    = 1'b0;
            vs_a_d    = 1'b0;
            blank_n_d = 1'b0;
            hsync_d   = 1'b1;
            vsync_d   = 1'b1;
            rgb_d     = 8'h00;
`ifdef VGA_TEST_PATTERN_EN
            col_a_d   = 10'd0;
`endif
        end else if (running && bus.pixel_pulse) begin
            state_d   = RUN;
            blank_n_d = act_a_q;
            hsync_d   = ~hs_a_q;
            vsync_d   = ~vs_a_q;
            rgb_d     = act_a_q ? pix_rgb : 8'h00;
            act_a_d   = active;
            hs_a_d    = hs;
            vs_a_d    = vs;
`ifdef VGA_TEST_PATTERN_EN
            col_a_d   = bus.col;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            act_a_q    <= 1'b0;
            hs_a_q     <= 1'b0;
            vs_a_q     <= 1'b0;
            blank_n_q  <= 1'b0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            rgb_q      <= 8'h00;
            sync_err_q <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
            col_a_q    <= 10'd0;
`endif
        end else begin
            state_q    <= state_d;
            act_a_q    <= act_a_d;
            hs_a_q     <= hs_a_d;
            vs_a_q     <= vs_a_d;
            blank_n_q  <= blank_n_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            rgb_q      <= rgb_d;
            sync_err_q <= sync_err_d;
`ifdef VGA_TEST_PATTERN_EN
            col_a_q    <= col_a_d;
`endif
        end
    end

    assign bus.addr_enable = advance;
    assign hsync           = hsync_q;
    assign vsync           = vsync_q;
    assign blank_n         = blank_n_q;
    assign red             = rgb_q[7:5];
    assign green           = rgb_q[4:2];
    assign blue            = rgb_q[1:0];
    assign sync_err        = sync_err_q;
    assign dbg_state       = (state_q == RUN);
endmodule

// File: tb/tb_vga_display_ctrl.sv
// Bench for vga_display_ctrl on a scaled-down raster (16x6 visible, 24x10 total).
`timescale 1ns/1ps
module tb_vga_display_ctrl;
  localparam int HA = 16, HSS = 18, HSE = 21, HT = 24;
  localparam int VA = 6, VSS = 7, VSE = 9, VT = 10;
  localparam int NPIX = HA * VA;

  logic clk = 1'b0;
  logic rst, enable;
`ifdef VGA_TEST_PATTERN_EN
  logic pattern_sel;
`endif
  logic hsync, vsync, blank_n, sync_err, dbg_state;
  logic [2:0] red, green;
  logic [1:0] blue;

  vga_display_ctrl_if bus();

  vga_display_ctrl #(
    .H_ACTIVE(10'd16), .H_SYNC_START(10'd18), .H_SYNC_END(10'd21),
    .V_ACTIVE(10'd6), .V_SYNC_START(10'd7), .V_SYNC_END(10'd9)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .bus(bus), .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
    .red(red), .green(green), .blue(blue), .sync_err(sync_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int c, r, lc, lr, addr;
  bit exp_run, exp_serr, p_act, p_hs, p_vs;
  int p_col;
  bit mask_last, force_last, data_ovr_en, pat_on;
  logic [7:0] data_ovr;
  int ae_cnt, hs_low_cnt, vs_low_cnt, blank_cnt;

  function automatic bit is_act(input int x, input int y);
    return (x < HA) && (y < VA);
  endfunction
  function automatic logic [7:0] bar_of(input int x);
    int n;
    n = x / (HA / 8);
    return (n >= 7) ? 8'hFF : 8'(n * 36);
  endfunction

  // One pixel period: strobe clk, then a quiet clk; timer advances afterwards.
  task automatic pix();
    logic [7:0] d, exp_rgb;
    logic [12:0] exp_v, got_v;
    bit exp_ae, act_now, last_drv;
    logic e_blank, e_hs, e_vs;
    if (!exp_run && enable && c == 0 && r == 0) begin
      exp_run = 1; p_act = 0; p_hs = 0; p_vs = 0; p_col = 0;
    end
    act_now  = is_act(c, r);
    exp_ae   = exp_run && act_now;
    d        = data_ovr_en ? data_ovr : 8'((addr * 37 + 19) % 256);
    last_drv = force_last || ((addr == NPIX - 1) && !mask_last);
    bus.col = 10'(c); bus.row = 10'(r); bus.pixel_data = d;
    bus.addr_last = last_drv; bus.pixel_pulse = 1'b1;
    #1;
    n_cmp++;
    if (bus.addr_enable !== exp_ae) begin
      n_err++;
      $display("FAIL addr_enable at (%0d,%0d): got %b want %b", c, r, bus.addr_enable, exp_ae);
    end
    if (exp_ae && ((c == HA - 1 && r == VA - 1) != last_drv)) exp_serr = 1;
    @(posedge clk); #1;
    bus.pixel_pulse = 1'b0;
    if (exp_ae) begin
      ae_cnt++;
      addr = (addr == NPIX - 1) ? 0 : addr + 1;
    end
    if (exp_run) begin
      e_blank = p_act; e_hs = ~p_hs; e_vs = ~p_vs;
      exp_rgb = pat_on ? bar_of(p_col) : d;
      if (!p_act) exp_rgb = 8'h00;
      p_act = act_now; p_hs = (c >= HSS && c < HSE); p_vs = (r >= VSS && r < VSE); p_col = c;
    end else begin
      e_blank = 0; e_hs = 1; e_vs = 1; exp_rgb = 8'h00;
    end
    exp_v = {e_blank, e_hs, e_vs, exp_rgb, exp_serr, exp_run};
    got_v = {blank_n, hsync, vsync, red, green, blue, sync_err, dbg_state};
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL outputs after (%0d,%0d) {blank,hs,vs,rgb,err,st}: got %h want %h", c, r, got_v, exp_v);
    end
    if (!hsync) hs_low_cnt++;
    if (!vsync) vs_low_cnt++;
    if (blank_n) blank_cnt++;
    @(posedge clk); #1;
    n_cmp++;
    if ({blank_n, hsync, vsync, red, green, blue, sync_err, dbg_state} !== got_v) begin
      n_err++;
      $display("FAIL hold after (%0d,%0d): got %h want %h", c, r,
               {blank_n, hsync, vsync, red, green, blue, sync_err, dbg_state}, got_v);
    end
    lc = c; lr = r;
    if (c == HT - 1) begin c = 0; r = (r == VT - 1) ? 0 : r + 1; end
    else c = c + 1;
  endtask

  task automatic run_to(input int tc, input int tr);
    int budget;
    budget = HT * VT + 1;
    while (!(c == tc && r == tr) && budget > 0) begin pix(); budget--; end
    n_cmp++;
    if (!(c == tc && r == tr)) begin
      n_err++;
      $display("FAIL run_to budget: at (%0d,%0d) want (%0d,%0d)", c, r, tc, tr);
    end
  endtask

  task automatic do_reset();
    rst = 1; bus.pixel_pulse = 1'b0;
    @(posedge clk); #1;
    rst = 0;
    exp_run = 0; exp_serr = 0; addr = 0; p_act = 0; p_hs = 0; p_vs = 0;
    n_cmp++;
    if ({blank_n, hsync, vsync, red, green, blue, sync_err, dbg_state} !== 13'b0_1_1_00000000_0_0) begin
      n_err++;
      $display("FAIL mid_reset: got %h want %h",
               {blank_n, hsync, vsync, red, green, blue, sync_err, dbg_state}, 13'b0_1_1_00000000_0_0);
    end
  endtask

  task automatic test_reset();
    rst = 1; enable = 1;
    bus.col = 10'd0; bus.row = 10'd0; bus.pixel_data = 8'hFF; bus.addr_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.pixel_pulse = (i % 2 == 0);
      @(posedge clk); #1;
      n_cmp++;
      if ({blank_n, hsync, vsync, red, green, blue, sync_err, dbg_state} !== 13'b0_1_1_00000000_0_0) begin
        n_err++;
        $display("FAIL reset cycle %0d: got %h want %h", i,
                 {blank_n, hsync, vsync, red, green, blue, sync_err, dbg_state}, 13'b0_1_1_00000000_0_0);
      end
    end
    rst = 0; bus.pixel_pulse = 1'b0;
    exp_run = 0; exp_serr = 0; addr = 0; c = 5; r = 3;
  endtask

  task automatic test_wait_origin();
    ae_cnt = 0;
    run_to(0, 0);
    n_cmp++;
    if (ae_cnt !== 0) begin n_err++; $display("FAIL pre_origin_ae: got %0d want 0", ae_cnt); end
  endtask

  task automatic test_full_frame();
    ae_cnt = 0; hs_low_cnt = 0; vs_low_cnt = 0; blank_cnt = 0;
    data_ovr_en = 1; data_ovr = 8'hE3;
    pix(); pix();
    data_ovr_en = 0;
    n_cmp++;
    if ({red, green, blue, blank_n} !== {3'd7, 3'd0, 2'd3, 1'b1}) begin
      n_err++;
      $display("FAIL pixel_e3: got %h want %h", {red, green, blue, blank_n}, {3'd7, 3'd0, 2'd3, 1'b1});
    end
    run_to(0, 0);
    n_cmp++; if (ae_cnt !== NPIX) begin n_err++; $display("FAIL ae_per_frame: got %0d want %0d", ae_cnt, NPIX); end
    n_cmp++; if (hs_low_cnt !== 30) begin n_err++; $display("FAIL hsync_low_count: got %0d want 30", hs_low_cnt); end
    n_cmp++; if (vs_low_cnt !== 48) begin n_err++; $display("FAIL vsync_low_count: got %0d want 48", vs_low_cnt); end
    n_cmp++; if (blank_cnt !== NPIX) begin n_err++; $display("FAIL blank_high_count: got %0d want %0d", blank_cnt, NPIX); end
    n_cmp++; if (sync_err !== 1'b0) begin n_err++; $display("FAIL sync_err_clean: got %b want 0", sync_err); end
  endtask

  task automatic test_sync_timing();
    logic got, want;
    bit chk;
    for (int i = 0; i < HT * VT; i++) begin
      pix();
      chk = 1; got = 1'b0; want = 1'b0;
      case (lr * 100 + lc)
        218: begin got = hsync; want = 1'b1; end
        219: begin got = hsync; want = 1'b0; end
        221: begin got = hsync; want = 1'b0; end
        222: begin got = hsync; want = 1'b1; end
        216: begin got = blank_n; want = 1'b1; end
        217: begin got = blank_n; want = 1'b0; end
        700: begin got = vsync; want = 1'b1; end
        701: begin got = vsync; want = 1'b0; end
        900: begin got = vsync; want = 1'b0; end
        901: begin got = vsync; want = 1'b1; end
        default: chk = 0;
      endcase
      if (chk) begin
        n_cmp++;
        if (got !== want) begin
          n_err++;
          $display("FAIL sync_edge after (%0d,%0d): got %b want %b", lc, lr, got, want);
        end
      end
    end
  endtask

  task automatic test_sync_err();
    run_to(HA - 1, VA - 1);
    mask_last = 1; pix(); mask_last = 0;
    n_cmp++; if (sync_err !== 1'b1) begin n_err++; $display("FAIL sync_err_missing_last: got %b want 1", sync_err); end
    run_to(0, 0); pix();
    n_cmp++; if (sync_err !== 1'b1) begin n_err++; $display("FAIL sync_err_sticky: got %b want 1", sync_err); end
    do_reset();
    run_to(0, 0); run_to(3, 1);
    force_last = 1; pix(); force_last = 0;
    n_cmp++; if (sync_err !== 1'b1) begin n_err++; $display("FAIL sync_err_early_last: got %b want 1", sync_err); end
    do_reset();
  endtask

  task automatic test_enable_drop();
    run_to(0, 0); run_to(12, 3); pix();
    enable = 0;
    @(posedge clk); #1;
    exp_run = 0; p_act = 0; p_hs = 0; p_vs = 0; addr = 0;
    n_cmp++;
    if ({blank_n, hsync, vsync, red, green, blue, sync_err, dbg_state} !== 13'b0_1_1_00000000_0_0) begin
      n_err++;
      $display("FAIL enable_drop: got %h want %h",
               {blank_n, hsync, vsync, red, green, blue, sync_err, dbg_state}, 13'b0_1_1_00000000_0_0);
    end
    ae_cnt = 0;
    for (int i = 0; i < 6; i++) pix();
    enable = 1;
    run_to(0, 0);
    n_cmp++; if (ae_cnt !== 0) begin n_err++; $display("FAIL reenable_before_origin: got %0d want 0", ae_cnt); end
    pix(); pix(); pix();
    n_cmp++; if (ae_cnt !== 3) begin n_err++; $display("FAIL reenable_resume: got %0d want 3", ae_cnt); end
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    logic [7:0] want;
    bit chk;
    run_to(0, 0);
    pattern_sel = 1; pat_on = 1;
    for (int i = 0; i < HA; i++) begin
      pix();
      chk = 1; want = 8'h00;
      case (lc)
        1:  want = 8'h00;
        3:  want = 8'h24;
        15: want = 8'hFF;
        default: chk = 0;
      endcase
      if (chk) begin
        n_cmp++;
        if ({red, green, blue} !== want) begin
          n_err++;
          $display("FAIL pattern_bar after col %0d: got %h want %h", lc, {red, green, blue}, want);
        end
      end
    end
    pattern_sel = 0; pat_on = 0;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.pixel_pulse = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
    pattern_sel = 1'b0;
`endif
    mask_last = 0; force_last = 0; data_ovr_en = 0; data_ovr = 8'h00; pat_on = 0;
    ae_cnt = 0; hs_low_cnt = 0; vs_low_cnt = 0; blank_cnt = 0;
    test_reset();
    test_wait_origin();
    test_full_frame();
    test_sync_timing();
    test_sync_err();
    test_enable_drop();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/vga_display_ctrl.md
VGA_DISPLAY_CTRL -- requirements
Module: vga_display_ctrl

Interface
REQ-001 Parameter H_ACTIVE, 640, visible columns (col 0..639).
REQ-002 Parameter H_SYNC_START, 656, first hsync-active column.
REQ-003 Parameter H_SYNC_END, 752, first column after hsync.
REQ-004 Parameter V_ACTIVE, 480, visible rows (row 0..479).
REQ-005 Parameter V_SYNC_START, 490, first vsync-active row.
REQ-006 Parameter V_SYNC_END, 492, first row after vsync.
REQ-007 clk  input  1  system clock; the only clock.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 enable  input  1  display enable.
REQ-010 pixel_pulse  input  1  one-clk strobe per pixel period, from the timer's flag_pulse.
REQ-011 col  input  10  current column (0..799), from the timer's column counter.
REQ-012 row  input  10  current row (0..524), from the timer's row counter.
REQ-013 pixel_data  input  8  frame-buffer byte, RGB332, for the address currently presented.
REQ-014 addr_last  input  1  high when the frame-buffer address counter equals 0x4AFFF (flag_addr).
REQ-015 addr_enable  output  1  one-clk strobe advancing the frame-buffer address counter.
REQ-016 hsync, vsync  output  1 each  active-low syncs.
REQ-017 blank_n  output  1  high while displayed pixel is visible.
REQ-018 red/green/blue  output  3/3/2  pixel colour.
REQ-019 sync_err  output  1  sticky frame/address misalignment flag.

Function
REQ-020 FSM states IDLE and RUN; IDLE->RUN on pixel_pulse with enable=1, col=0, row=0; RUN->IDLE on enable=0 (next clk, any position).
REQ-021 active = (col < H_ACTIVE) && (row < V_ACTIVE); hs = col in [H_SYNC_START, H_SYNC_END); vs = row in [V_SYNC_START, V_SYNC_END).
REQ-022 addr_enable = pixel_pulse && state==RUN && active, combinational, high exactly one clk per visible pixel (307200 per frame).
REQ-023 Stage A, on pixel_pulse in RUN: register active, hs, vs of current col/row.
REQ-024 Stage B, on next pixel_pulse: blank_n<=active_A; hsync<=~hs_A; vsync<=~vs_A; rgb<=active_A ? pixel_data sampled this clk : 0.
REQ-025 Output latency: exactly 2 pixel_pulse strobes from col/row sample to outputs; outputs hold between strobes.
REQ-026 rgb mapping: red=pixel_data[7:5], green=[4:2], blue=[1:0].
REQ-027 In IDLE: addr_enable=0, pipeline flushed, hsync=vsync=1, blank_n=0, rgb=0.
REQ-028 sync_err set when addr_enable fires at col=639,row=479 with addr_last=0, or fires elsewhere with addr_last=1; cleared only by rst.
REQ-029 sync_err does not alter FSM state or outputs.
REQ-030 col/row values outside 0..799/0..524 are treated as non-visible, no sync.

Reset
REQ-031 rst sampled on rising clk only; state<=IDLE, Stage A/B cleared, hsync=vsync=1, blank_n=0, rgb=0, sync_err=0.
REQ-032 rst asserted mid-frame takes effect at the next edge; after release the FSM rejoins at the next col=0,row=0.
REQ-033 rst has priority over enable and pixel_pulse.

Configuration
REQ-034 Macro VGA_TEST_PATTERN_EN defined: adds input pattern_sel (1 bit); when high, Stage B rgb = colour bar index col_A/80 (8 bars, bar n = RGB332 value n*0x24 with 0xFF for bar 7), pixel_data ignored, addr_enable unchanged.
REQ-035 Macro undefined: no pattern_sel port; rgb always from pixel_data.

Verification
REQ-036 rst 3 clk, enable=1, drive timer-like col/row with pulse every 2 clk -> IDLE until col=0,row=0, then addr_enable count per frame = 307200.
REQ-037 Steady frame -> hsync low for 96 pulses per line (cols 656..751 delayed 2 pulses), vsync low rows 490..491, blank_n low at col 640 +2 pulses.
REQ-038 pixel_data=0xE3 at pixel (0,0) -> red=7, green=0, blue=3 two pulses later, blank_n=1.
REQ-039 addr_last=0 at (639,479) -> sync_err=1 next clk and stays 1 until rst; addr_last=1 -> sync_err stays 0.
REQ-040 enable dropped at (300,200) -> next clk outputs idle values, addr_enable=0; re-enable -> resume only at next (0,0).
REQ-041 With VGA_TEST_PATTERN_EN, pattern_sel=1 -> col 0..79 rgb=0x00, col 80..159 rgb=0x24, col 560..639 rgb=0xFF.
